sysid_boot_checker: RTL and testbench

Avalon-MM master that reads the system-ID peripheral's two words (word 0 = ID, word 1 = build timestamp) after reset or on request. It compares both words against build-time expected values and reports pass/fail/timeout flags to the boot-control logic. It sits directly downstream of the sysid slave on the Qsys interconnect and consumes its `readdata`. It also guards against a hung or missing slave with a per-transaction timeout.

---
 rtl/sysid_boot_checker.sv | 163 ++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: Avalon-MM master that reads the system-ID peripheral
// (word 0 = ID, word 1 = build timestamp) after reset or on request, compares
// both words against build-time constants and reports pass/fail/timeout.
// Every output is a register loaded from the next-state value, so no output
// depends combinationally on an input.

module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  // Counter value at which a transaction is abandoned.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIdReq,
    StIdWait,
    StTsReq,
    StTsWait,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        auto_pend_q, auto_pend_d;

  logic        avm_read_d, avm_address_d;
  logic        busy_d, done_d, id_ok_d, ts_ok_d, timeout_d;
  logic [31:0] captured_id_d, captured_ts_d;

  logic        in_req, in_wait, expired, restart;

  assign in_req  = (state_q == StIdReq) || (state_q == StTsReq);
  assign in_wait = (state_q == StIdWait) || (state_q == StTsWait);
  assign expired = (tcnt_q == TimeoutLast);

  // State and registered outputs; reset aborts any transaction immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      tcnt_q      <= '0;
      auto_pend_q <= AUTO_START;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      auto_pend_q <= auto_pend_d;
      avm_read    <= avm_read_d;
      avm_address <= avm_address_d;
      busy        <= busy_d;
      done        <= done_d;
      id_ok       <= id_ok_d;
      ts_ok       <= ts_ok_d;
      timeout     <= timeout_d;
      captured_id <= captured_id_d;
      captured_ts <= captured_ts_d;
    end
  end

  // Next-state logic; in a wait state, read data beats a same-cycle expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start || auto_pend_q) state_d = StIdReq;
      end
      StIdReq: begin
        if (expired)               state_d = StDone;
        else if (!avm_waitrequest) state_d = StIdWait;
      end
      StIdWait: begin
        if (avm_readdatavalid) state_d = StTsReq;
        else if (expired)      state_d = StDone;
      end
      StTsReq: begin
        if (expired)               state_d = StDone;
        else if (!avm_waitrequest) state_d = StTsWait;
      end
      StTsWait: begin
        if (avm_readdatavalid || expired) state_d = StDone;
      end
      StDone: begin
        if (start) state_d = StIdReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, timeout counter and auto-start bit.
  always_comb begin
    restart = ((state_q == StIdle) || (state_q == StDone)) && (state_d == StIdReq);

    avm_read_d    = (state_d == StIdReq) || (state_d == StTsReq);
    avm_address_d = avm_address;
    if (state_d == StIdReq) avm_address_d = 1'b0;
    if (state_d == StTsReq) avm_address_d = 1'b1;

    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);

    // Restart from zero on every entry into a request state.
    tcnt_d = tcnt_q;
    if (((state_d == StIdReq) || (state_d == StTsReq)) && (state_d != state_q)) begin
      tcnt_d = '0;
    end else if (in_req || in_wait) begin
      tcnt_d = tcnt_q + 16'd1;
    end

    auto_pend_d = auto_pend_q;
    if ((state_q == StIdle) && (state_d == StIdReq)) auto_pend_d = 1'b0;

    id_ok_d       = id_ok;
    ts_ok_d       = ts_ok;
    timeout_d     = timeout;
    captured_id_d = captured_id;
    captured_ts_d = captured_ts;

    if (restart) begin
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b0;
    end

    if ((state_q == StIdWait) && avm_readdatavalid) begin
      captured_id_d = avm_readdata;
      id_ok_d       = (avm_readdata == EXPECTED_ID);
    end
    if ((state_q == StTsWait) && avm_readdatavalid) begin
      captured_ts_d = avm_readdata;
      ts_ok_d       = (avm_readdata == EXPECTED_TIMESTAMP);
    end

    if (expired && (in_req || (in_wait && !avm_readdatavalid))) timeout_d = 1'b1;
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: a behavioural Avalon slave with per-word wait
// states / latency, a hand-computed vector table, a few reset/stray-valid
// sequences and randomized checks against a timing/flag reference model.

module tb_sysid_boot_checker;

  localparam logic [31:0] ExpId = 32'h12345678;
  localparam logic [31:0] ExpTs = 32'h5B586FC9;
  localparam int          Tmo   = 8;
  localparam int          Never = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic        slave_rdv = 1'b0, stray_rdv = 1'b0;
  logic [31:0] slave_data = '0, stray_data = '0;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] captured_id, captured_ts;

  assign avm_readdatavalid = slave_rdv | stray_rdv;
  assign avm_readdata      = stray_rdv ? stray_data : slave_data;

  sysid_boot_checker #(
    .EXPECTED_ID       (ExpId),
    .EXPECTED_TIMESTAMP(ExpTs),
    .TIMEOUT_CYCLES    (Tmo),
    .AUTO_START        (1'b1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata     (avm_readdata),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .timeout          (timeout),
    .captured_id      (captured_id),
    .captured_ts      (captured_ts)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave configuration, indexed by word address.
  int          cfg_wait[2];
  int          cfg_lat[2];
  logic [31:0] cfg_data[2];
  int          accepted   = 0;
  bit          slave_busy = 1'b0;

  task automatic set_cfg(input int w0, input int l0, input logic [31:0] d0,
                         input int w1, input int l1, input logic [31:0] d1);
    cfg_wait[0] = w0; cfg_lat[0] = l0; cfg_data[0] = d0;
    cfg_wait[1] = w1; cfg_lat[1] = l1; cfg_data[1] = d1;
  endtask

  // One read: stall for cfg_wait cycles, then return data cfg_lat cycles
  // after acceptance (cfg_lat == Never: no data at all).
  task automatic serve();
    int   a;
    logic addr0;
    bit   aborted;
    a = int'(avm_address);
    addr0 = avm_address;
    aborted = 1'b0;
    slave_busy = 1'b1;
    for (int i = 0; i < cfg_wait[a] && !aborted; i++) begin
      avm_waitrequest = 1'b1;
      @(negedge clock);
      if (!avm_read || reset) aborted = 1'b1;
      else check("stall_address_stable", {31'd0, avm_address}, {31'd0, addr0});
    end
    avm_waitrequest = 1'b0;
    if (!aborted) begin
      accepted++;
      if (cfg_lat[a] != Never) begin
        for (int i = 0; i < cfg_lat[a] && !aborted; i++) begin
          @(negedge clock);
          if (reset) aborted = 1'b1;
        end
        if (!aborted) begin
          slave_rdv  = 1'b1;
          slave_data = cfg_data[a];
        end
      end
    end
    slave_busy = 1'b0;
  endtask

  initial begin : slave
    forever begin
      @(negedge clock);
      slave_rdv  = 1'b0;
      slave_data = $urandom();
      if (avm_read && !reset) serve();
    end
  end

  typedef struct {
    string       name;
    int          w0, l0;
    logic [31:0] d0;
    int          w1, l1;
    logic [31:0] d1;
    int          xstart;  // cycle at which to pulse start while busy (-1: none)
    int          e_cyc;   // first cycle done is seen, start sampled at cycle 0
    bit          e_id, e_ts, e_to;
    logic [31:0] e_cid, e_cts;
    int          e_acc;
  } vec_t;

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("%s.done_reached", name), {31'd0, done}, 32'd1);
  endtask

  // Apply one check and compare it against the expectations in v.
  task automatic apply_vec(input vec_t v);
    int n;
    set_cfg(v.w0, v.l0, v.d0, v.w1, v.l1, v.d1);
    accepted = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    check($sformatf("%s.busy_c1", v.name), {31'd0, busy}, 32'd1);
    check($sformatf("%s.flags_clear_c1", v.name), {28'd0, done, id_ok, ts_ok, timeout}, 32'd0);
    while (!done && n < 80) begin
      if (n == v.xstart) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n++;
    end
    check($sformatf("%s.done_cycle", v.name), n, v.e_cyc);
    check($sformatf("%s.flags", v.name), {29'd0, id_ok, ts_ok, timeout},
          {29'd0, v.e_id, v.e_ts, v.e_to});
    check($sformatf("%s.captured_id", v.name), captured_id, v.e_cid);
    check($sformatf("%s.captured_ts", v.name), captured_ts, v.e_cts);
    check($sformatf("%s.read_busy_low", v.name), {30'd0, avm_read, busy}, 32'd0);
    n = 0;
    while (slave_busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    check($sformatf("%s.accepted", v.name), accepted, v.e_acc);
    check($sformatf("%s.done_held", v.name), {30'd0, done, busy}, 32'd2);
    check($sformatf("%s.flags_held", v.name), {29'd0, id_ok, ts_ok, timeout},
          {29'd0, v.e_id, v.e_ts, v.e_to});
    check($sformatf("%s.captured_id_held", v.name), captured_id, v.e_cid);
  endtask

  vec_t tbl[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t        v;
    logic [31:0] m_cid, m_cts;
    int          t0, t1, ts_entry, sel;

    // Hand-computed with Tmo = 8: a read resolves at counter value wait+lat,
    // and times out when that exceeds Tmo-1 (done appears Tmo cycles after
    // the request state is entered).
    tbl[0] = '{"nominal", 0, 1, ExpId, 0, 1, ExpTs, -1, 5, 1'b1, 1'b1, 1'b0, ExpId, ExpTs, 2};
    tbl[1] = '{"id_mismatch", 0, 1, 32'h12345679, 0, 1, ExpTs, -1, 5, 1'b0, 1'b1, 1'b0,
               32'h12345679, ExpTs, 2};
    // 3 wait states and latency 2 on both reads: 5 + 2*3 + 2*1.
    tbl[2] = '{"backpressure", 3, 2, ExpId, 3, 2, ExpTs, -1, 13, 1'b1, 1'b1, 1'b0,
               ExpId, ExpTs, 2};
    // TS_REQ entered at cycle 3, never answered: done at 3 + 8.
    tbl[3] = '{"ts_timeout", 0, 1, ExpId, 0, Never, 32'h0, -1, 11, 1'b1, 1'b0, 1'b1,
               ExpId, ExpTs, 2};
    // ID read never accepted: done at 1 + 8, captured words untouched.
    tbl[4] = '{"id_stall_timeout", 20, 1, 32'h0, 0, 1, 32'h0, -1, 9, 1'b0, 1'b0, 1'b1,
               ExpId, ExpTs, 0};
    // Data on the expiry cycle (2 + 5 = 7) wins; TS_REQ at 9, done at 11.
    tbl[5] = '{"valid_at_expiry", 2, 5, 32'hCAFEF00D, 0, 1, ExpTs, -1, 11, 1'b0, 1'b1, 1'b0,
               32'hCAFEF00D, ExpTs, 2};
    // One cycle later (3 + 5 = 8) is a timeout; the late data lands in DONE.
    tbl[6] = '{"valid_after_expiry", 3, 5, 32'h0BADBEEF, 0, 1, ExpTs, -1, 9, 1'b0, 1'b0, 1'b1,
               32'hCAFEF00D, ExpTs, 1};
    tbl[7] = '{"start_while_busy", 0, 1, ExpId, 0, 1, ExpTs, 2, 5, 1'b1, 1'b1, 1'b0,
               ExpId, ExpTs, 2};

    // Reset state, then the automatic check after release.
    set_cfg(0, 1, ExpId, 0, 1, ExpTs);
    @(negedge clock);
    check("reset_outputs", {26'd0, avm_address, avm_read, busy, done, id_ok, ts_ok, timeout},
          32'd0);
    check("reset_captured", captured_id | captured_ts, 32'd0);
    reset = 1'b0;
    wait_done("autostart");
    check("autostart.flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
    check("autostart.captured_ts", captured_ts, ExpTs);
    repeat (2) @(negedge clock);

    foreach (tbl[i]) apply_vec(tbl[i]);

    // Stray valid in DONE must leave everything alone.
    stray_data = 32'hDEADBEEF;
    stray_rdv  = 1'b1;
    @(negedge clock);
    stray_rdv  = 1'b0;
    @(negedge clock);
    check("stray_valid.flags", {27'd0, done, busy, id_ok, ts_ok, timeout}, 32'h16);
    check("stray_valid.captured_id", captured_id, ExpId);
    check("stray_valid.captured_ts", captured_ts, ExpTs);

    // Reset while the ID request is stalled: avm_read drops at once.
    set_cfg(5, 1, ExpId, 0, 1, ExpTs);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("rst_req.read_before", {31'd0, avm_read}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_req.read_after", {30'd0, avm_read, busy}, 32'd0);
    repeat (3) @(negedge clock);
    set_cfg(0, 1, ExpId, 0, 1, ExpTs);
    reset = 1'b0;
    wait_done("rst_req.rerun");
    check("rst_req.rerun_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
    repeat (2) @(negedge clock);

    // Reset during ID_WAIT clears flags and captured words immediately.
    set_cfg(0, 4, ExpId, 0, 1, ExpTs);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("rst_wait.in_wait", {30'd0, avm_read, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_wait.outputs", {26'd0, avm_address, avm_read, busy, done, id_ok, ts_ok, timeout},
          32'd0);
    check("rst_wait.captured", captured_id | captured_ts, 32'd0);
    repeat (3) @(negedge clock);
    set_cfg(0, 1, ExpId, 0, 1, ExpTs);
    reset = 1'b0;
    wait_done("rst_wait.rerun");
    check("rst_wait.rerun_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
    check("rst_wait.rerun_captured_id", captured_id, ExpId);
    repeat (2) @(negedge clock);

    // Randomized checks against the reference model.
    m_cid = ExpId;
    m_cts = ExpTs;
    for (int k = 0; k < 24; k++) begin
      v.name = $sformatf("rand%0d", k);
      v.w0 = int'($urandom_range(0, 3));
      v.l0 = int'($urandom_range(1, 5));
      v.w1 = int'($urandom_range(0, 3));
      v.l1 = int'($urandom_range(1, 5));
      v.d0 = $urandom_range(0, 1) != 0 ? ExpId : $urandom();
      v.d1 = $urandom_range(0, 1) != 0 ? ExpTs : $urandom();
      sel = int'($urandom_range(0, 3));
      v.xstart = (sel == 0) ? -1 : sel + 1;
      v.e_id = 1'b0;
      v.e_ts = 1'b0;
      v.e_to = 1'b0;
      t0 = v.w0 + v.l0;
      if (t0 > Tmo - 1) begin
        v.e_cyc = 1 + Tmo;
        v.e_to  = 1'b1;
        v.e_acc = 1;
      end else begin
        m_cid    = v.d0;
        v.e_id   = (v.d0 == ExpId);
        ts_entry = t0 + 2;
        t1       = v.w1 + v.l1;
        v.e_acc  = 2;
        if (t1 > Tmo - 1) begin
          v.e_cyc = ts_entry + Tmo;
          v.e_to  = 1'b1;
        end else begin
          m_cts   = v.d1;
          v.e_ts  = (v.d1 == ExpTs);
          v.e_cyc = ts_entry + t1 + 1;
        end
      end
      v.e_cid = m_cid;
      v.e_cts = m_cts;
      apply_vec(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
